data_io_wide: RTL
=================

# data_io_wide

Parametrised successor to the byte-wide download path. It runs entirely in the `clk_sys` domain and takes bytes already brought over from the SPI receiver. It packs them into `DW`-bit words with byte enables, buffers them in a small FIFO, and presents them to the core's memory port on `clkref_n` slots. Unlike the byte-wide path, it supports 8/16/32-bit targets, partial final words, back-pressure buffering and overflow reporting.

## Interface
- `DW`, 8: output word width; legal values are 8, 16 and 32. `NB = DW/8` lanes.
- `START_ADDR`, 25'd0: byte address loaded at every transfer start.
- `FIFO_DEPTH`, 4: word FIFO entries; must be a power of 2 and at least 2.
- `clk_sys`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `dl_start`  in  1  one-cycle pulse; begins a transfer.
- `dl_end`  in  1  one-cycle pulse; ends the transfer.
- `rx_wr`  in  1  one-cycle strobe; `rx_data` is valid.
- `rx_data`  in  8  received byte.
- `rx_index`  in  8  menu index; sampled on `dl_start`.
- `clkref_n`  in  1  write slot enable, active low.
- `ioctl_download`  out  1  transfer active.
- `ioctl_index`  out  8  latched menu index.
- `ioctl_wr`  out  1  one-cycle write strobe.
- `ioctl_addr`  out  25  byte address of lane 0 of `ioctl_dout`.
- `ioctl_dout`  out  DW  packed data; the first byte of a word goes in lane 0, bits [7:0].
- `ioctl_be`  out  NB  lane enables for `ioctl_dout`.
- `ioctl_overflow`  out  1  sticky flag; a word was dropped.

## Operation
- **Reset values:**
  - All outputs are 0.
  - The internal address is `START_ADDR`.
  - The lane counter is 0, the FIFO is empty and the state is IDLE.
- **States:**
  - IDLE → ACTIVE on `dl_start`.
  - ACTIVE → FLUSH on `dl_end`.
  - FLUSH → IDLE when the packer and the FIFO are both empty.
  - `dl_start` in any state → ACTIVE. It clears the packer, FIFO and overflow flag, loads the address with `START_ADDR` and latches `ioctl_index <= rx_index`.
- **Packer:**
  - `rx_wr` in ACTIVE writes `rx_data` into lane `lane` and sets that lane's bit in the pending enable mask.
  - `lane` increments modulo `NB`.
  - When `lane == NB-1`, the word and its enable mask (all ones) are pushed to the FIFO, and the mask clears.
  - With `DW=8`, every byte is pushed and `be` is always 1.
- **`rx_wr` outside ACTIVE:**
  - It is ignored in IDLE and FLUSH.
  - The exception is `rx_wr` in the same cycle as `dl_start`: that byte becomes lane 0 of the new transfer.
- **`dl_end` and the packer:**
  - If `rx_wr` coincides with `dl_end`, the byte is packed first.
  - If the resulting mask is nonzero, the partial word is pushed with that mask. Unused lanes read 0.
  - The lane counter then resets to 0.
- **FIFO overflow:**
  - A push while the FIFO is full, with no pop in the same cycle, drops the word and sets `ioctl_overflow`.
  - A push and a pop in the same cycle on a full FIFO both succeed.
- **Emitter:**
  - In a cycle where `clkref_n == 0` and the FIFO is non-empty, the FIFO head is popped.
  - The next cycle shows `ioctl_wr = 1`, with `ioctl_dout`/`ioctl_be` taken from the head and `ioctl_addr` equal to the internal address.
  - The internal address then advances by `NB` and wraps modulo 2^25.
  - `ioctl_dout`, `ioctl_be` and `ioctl_addr` hold their values until the next write.
- **Address:** advances by `NB` per emitted word, partial words included. Dropped words do not advance it.
- **`ioctl_download`:** 1 in ACTIVE and FLUSH, 0 in IDLE.

## Timing
- **Latency:**
  - The `rx_wr` that completes a word at cycle N pushes it into the FIFO at N+1.
  - With `clkref_n` held low, `ioctl_wr` is high at cycle N+2.
- **Throughput:** at most one `ioctl_wr` per cycle. `ioctl_wr` is never high for two consecutive cycles unless `clkref_n` is low in both preceding cycles.
- **`ioctl_download`:**
  - Rises the cycle after `dl_start`.
  - Falls the cycle after the last pending `ioctl_wr` pulse. With nothing pending, it falls the cycle after `dl_end`.
- **`dl_start` mid-FLUSH:** discards pending words. No further `ioctl_wr` is issued for the old transfer.
- **`reset` mid-transfer:** outputs return to their reset values immediately, with no clock required.

## Test plan
- **32-bit stream:** `DW=32`, `clkref_n=0`; `dl_start` with `rx_index=8'h05`, then bytes 11,22,33,44,55,66,77,88, then `dl_end`.
  - Expect writes `addr 0 / 32'h44332211 / be 4'hF` and `addr 4 / 32'h88776655 / be 4'hF`, and `ioctl_index=5`.
  - `ioctl_download` falls one cycle after the second write.
- **Partial final word:** `DW=32`, 5 bytes AA..EE, then `dl_end`.
  - Second write: `addr 4, dout 32'h000000EE, be 4'h1`.
- **Back-pressure and overflow:** `DW=16`, `FIFO_DEPTH=4`, `clkref_n=1`, send 12 bytes.
  - `ioctl_overflow=1` after the 5th word.
  - Releasing `clkref_n` yields 4 writes at addresses 0,2,4,6 holding the first 4 words.
  - The next `dl_start` clears the flag.
- **Restart mid-transfer:** `DW=16`, `clkref_n=1`; 4 bytes, then `dl_start` with `START_ADDR=25'h100`, then 2 bytes, then `clkref_n=0`.
  - Expect exactly one write: `addr 25'h100` with the new bytes.
- **Coincident events:** `rx_wr` with `dl_start`, and `rx_wr` with `dl_end`.
  - Both bytes are included, in the first word and the last word respectively.
- **Async reset:** assert `reset` while a write is pending with no `clk_sys` edge.
  - All outputs are 0 immediately, and no `ioctl_wr` follows after reset is released.

Source files
------------

// File: rtl/data_io_wide.sv
// data_io_wide
// Packs received bytes into DW-bit words with byte enables, buffers the words
// in a small FIFO and writes them to the core's memory port on clkref_n slots.
//
// Ports:
//   clk_sys        sole clock, rising edge
//   reset          asynchronous, active-high, clears all state
//   dl_start       pulse, begins a transfer (also aborts a running one)
//   dl_end         pulse, ends the transfer and flushes a partial word
//   rx_wr/rx_data  received byte strobe and data
//   rx_index       menu index, latched on dl_start
//   clkref_n       write slot enable, active low
//   ioctl_download transfer active (ACTIVE or FLUSH)
//   ioctl_index    latched menu index
//   ioctl_wr       one-cycle write strobe
//   ioctl_addr     byte address of lane 0 of ioctl_dout
//   ioctl_dout     packed word, first byte in bits [7:0]
//   ioctl_be       lane enables for ioctl_dout
//   ioctl_overflow sticky, a word was dropped on a full FIFO
module data_io_wide #(
  parameter int          DW         = 8,
  parameter logic [24:0] START_ADDR = 25'd0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            dl_start,
  input  logic            dl_end,
  input  logic            rx_wr,
  input  logic [7:0]      rx_data,
  input  logic [7:0]      rx_index,
  input  logic            clkref_n,
  output logic            ioctl_download,
  output logic [7:0]      ioctl_index,
  output logic            ioctl_wr,
  output logic [24:0]     ioctl_addr,
  output logic [DW-1:0]   ioctl_dout,
  output logic [DW/8-1:0] ioctl_be,
  output logic            ioctl_overflow
);

  localparam int NB = DW / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NB - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [DW-1:0]   pack_data_q, pack_data_d;
  logic [NB-1:0]   pack_be_q, pack_be_d;
  logic [DW-1:0]   mem_data_q [FIFO_DEPTH];
  logic [DW-1:0]   mem_data_d [FIFO_DEPTH];
  logic [NB-1:0]   mem_be_q [FIFO_DEPTH];
  logic [NB-1:0]   mem_be_d [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [24:0]     addr_q, addr_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      index_q, index_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [NB-1:0]   be_q, be_d;
  logic [24:0]     oaddr_q, oaddr_d;
  logic            download_q, download_d;

  logic            pop, push, take_byte, end_now, full_word;
  logic [LW-1:0]   lane_base;
  logic [DW-1:0]   data_base, word_data;
  logic [NB-1:0]   be_base, word_be;
  logic [AW-1:0]   wptr_base;
  logic [CW-1:0]   count_base;
  int              lane_idx;

  // Next-state logic for packer, FIFO, emitter and transfer state.
  always_comb begin
    state_d     = state_q;
    mem_data_d  = mem_data_q;
    mem_be_d    = mem_be_q;
    rptr_d      = rptr_q;
    addr_d      = addr_q;
    overflow_d  = overflow_q;
    dout_d      = dout_q;
    be_d        = be_q;
    oaddr_d     = oaddr_q;

    // A restart must not let a word of the old transfer reach the port.
    pop = ~clkref_n && (count_q != CW'(0)) && ~dl_start;
    if (pop) begin
      wr_d    = 1'b1;
      dout_d  = mem_data_q[rptr_q];
      be_d    = mem_be_q[rptr_q];
      oaddr_d = addr_q;
      addr_d  = addr_q + 25'(NB);
      rptr_d  = rptr_q + AW'(1);
    end else begin
      wr_d    = 1'b0;
    end

    // dl_start starts from an empty packer, so a coincident byte lands in lane 0.
    if (dl_start) begin
      lane_base = LW'(0);
      data_base = DW'(0);
      be_base   = NB'(0);
    end else begin
      lane_base = lane_q;
      data_base = pack_data_q;
      be_base   = pack_be_q;
    end

    take_byte = rx_wr && (dl_start || (state_q == ST_ACTIVE));
    end_now   = dl_end && ~dl_start && (state_q == ST_ACTIVE);
    lane_idx  = int'(lane_base);
    word_data = data_base;
    word_be   = be_base;
    if (take_byte) begin
      word_data[lane_idx*8 +: 8] = rx_data;
      word_be[lane_base]         = 1'b1;
    end else begin
      word_be   = be_base;
    end

    full_word = take_byte && (lane_base == LAST_LANE);
    push      = full_word || (end_now && (word_be != NB'(0)));

    // Clearing the data as well as the mask keeps unused lanes of a partial word at 0.
    if (push || end_now) begin
      lane_d      = LW'(0);
      pack_data_d = DW'(0);
      pack_be_d   = NB'(0);
    end else if (take_byte) begin
      lane_d      = lane_base + LW'(1);
      pack_data_d = word_data;
      pack_be_d   = word_be;
    end else begin
      lane_d      = lane_base;
      pack_data_d = data_base;
      pack_be_d   = be_base;
    end

    // The pop is accounted first so a full FIFO still accepts a push in a pop cycle.
    if (dl_start) begin
      wptr_base  = AW'(0);
      count_base = CW'(0);
      rptr_d     = AW'(0);
      overflow_d = 1'b0;
    end else begin
      wptr_base  = wptr_q;
      count_base = count_q - (pop ? CW'(1) : CW'(0));
    end
    wptr_d  = wptr_base;
    count_d = count_base;
    if (push) begin
      if (count_base < DEPTH_C) begin
        mem_data_d[wptr_base] = word_data;
        mem_be_d[wptr_base]   = word_be;
        wptr_d                = wptr_base + AW'(1);
        count_d               = count_base + CW'(1);
      end else begin
        overflow_d            = 1'b1;
      end
    end else begin
      count_d = count_base;
    end

    // With nothing left to write, dl_end drops straight back to IDLE.
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_ACTIVE: begin
        if (dl_end) begin
          state_d = (push || (count_q != CW'(0))) ? ST_FLUSH : ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        if (count_q == CW'(0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    if (dl_start) begin
      state_d = ST_ACTIVE;
      index_d = rx_index;
      addr_d  = START_ADDR;
    end else begin
      index_d = index_q;
    end

    download_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= LW'(0);
      pack_data_q <= DW'(0);
      pack_be_q   <= NB'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= DW'(0);
        mem_be_q[i]   <= NB'(0);
      end
      wptr_q      <= AW'(0);
      rptr_q      <= AW'(0);
      count_q     <= CW'(0);
      addr_q      <= START_ADDR;
      overflow_q  <= 1'b0;
      index_q     <= 8'd0;
      wr_q        <= 1'b0;
      dout_q      <= DW'(0);
      be_q        <= NB'(0);
      oaddr_q     <= 25'd0;
      download_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      pack_data_q <= pack_data_d;
      pack_be_q   <= pack_be_d;
      mem_data_q  <= mem_data_d;
      mem_be_q    <= mem_be_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
      index_q     <= index_d;
      wr_q        <= wr_d;
      dout_q      <= dout_d;
      be_q        <= be_d;
      oaddr_q     <= oaddr_d;
      download_q  <= download_d;
    end
  end

  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = oaddr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_be       = be_q;
  assign ioctl_overflow = overflow_q;

endmodule
